// File: rtl/nt_probe_pkg.sv
// Shared types and constants for the Nt-node probe sequencers.
package nt_probe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_DRIVE,
        ST_DRAIN,
        ST_CHECK
    } state_e;

    localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
    localparam logic [15:0] MISR_POLY    = 16'h1021;
    localparam int          FLUSH_CYCLES = 2;
    localparam int          MISR_W       = 16;

    // Left-shifting Fibonacci step; feedback is the parity of the tapped bits.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/nt_probe_misr.sv
// 16-bit MISR with synchronous clear and capture enable; also exposes next value.
module nt_probe_misr
    import nt_probe_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              din_i,
    output logic [MISR_W-1:0] sig_o,
    output logic [MISR_W-1:0] sig_next_o
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[MISR_W-2:0], 1'b0}
                  ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                  ^ {{(MISR_W-1){1'b0}}, din_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o      = sig_q;
    assign sig_next_o = sig_d;

endmodule

// File: rtl/nt_probe_sequencer.sv
// Resets an Nt-node subcircuit, drives LFSR patterns into it and compacts its
// response into a MISR signature that is compared against a golden value.
module nt_probe_sequencer
    import nt_probe_pkg::*;
#(
    parameter int          PATTERNS  = 64,
    parameter int          LAT       = 1,
    parameter logic [7:0]  LFSR_SEED = 8'h01,
    parameter logic [15:0] GOLDEN    = 16'h0000
) (
    input  logic        I1470_clk,
    input  logic        I1477_rst,
    input  logic        start,
    output logic [2:0]  dut_d,
    output logic        dut_rst,
    input  logic        dut_q,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [10:0] pat_cnt
);

    localparam logic [7:0]  SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [10:0] FLUSH_LAST = 11'(FLUSH_CYCLES - 1);
    localparam logic [10:0] PAT_LAST   = 11'(PATTERNS - 1);
    localparam logic [10:0] PAT_MAX    = 11'(PATTERNS);
    localparam logic [10:0] LAT_LAST   = 11'(LAT - 1);

    state_e            state_q, state_d;
    logic [10:0]       cyc_q, cyc_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [LAT-1:0]    pipe_q, pipe_d, pipe_shift;
    logic [10:0]       pat_cnt_q, pat_cnt_d;
    logic [2:0]        dut_d_q, dut_d_d;
    logic              dut_rst_q, busy_q, done_q;
    logic              pass_q, pass_d;
    logic              accept;
    logic [MISR_W-1:0] misr_sig, misr_next;

    assign accept = (state_q == ST_IDLE) && start;

    // A pattern is on dut_d while state_q is DRIVE; its response lands LAT cycles later.
    generate
        if (LAT == 1) begin : g_pipe_one
            assign pipe_shift = (state_q == ST_DRIVE);
        end else begin : g_pipe_many
            assign pipe_shift = {pipe_q[LAT-2:0], (state_q == ST_DRIVE)};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + 11'd1;
        case (state_q)
            ST_IDLE: begin
                cyc_d = '0;
                if (start) state_d = ST_FLUSH;
            end
            ST_FLUSH: if (cyc_q == FLUSH_LAST) begin
                state_d = ST_DRIVE;
                cyc_d   = '0;
            end
            ST_DRIVE: if (cyc_q == PAT_LAST) begin
                state_d = ST_DRAIN;
                cyc_d   = '0;
            end
            ST_DRAIN: if (cyc_q == LAT_LAST) begin
                state_d = ST_CHECK;
                cyc_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = '0;
            end
        endcase
    end

    always_comb begin
        lfsr_d    = lfsr_q;
        pat_cnt_d = pat_cnt_q;
        pass_d    = pass_q;
        pipe_d    = pipe_shift;
        if (accept) begin
            lfsr_d    = SEED;
            pat_cnt_d = '0;
            pass_d    = 1'b0;
            pipe_d    = '0;
        end else begin
            if (state_q == ST_DRIVE) begin
                lfsr_d = lfsr_step(lfsr_q);
                if (pat_cnt_q != PAT_MAX) pat_cnt_d = pat_cnt_q + 11'd1;
            end
            // Compare the value the MISR takes on this edge, so pass is valid with done.
            if (state_d == ST_CHECK) pass_d = (misr_next == GOLDEN);
        end
        dut_d_d = (state_d == ST_DRIVE) ? lfsr_d[2:0] : 3'b000;
    end

    always_ff @(posedge I1470_clk) begin
        if (!I1477_rst) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            lfsr_q    <= 8'h01;
            pipe_q    <= '0;
            pat_cnt_q <= '0;
            dut_d_q   <= '0;
            dut_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            lfsr_q    <= lfsr_d;
            pipe_q    <= pipe_d;
            pat_cnt_q <= pat_cnt_d;
            dut_d_q   <= dut_d_d;
            dut_rst_q <= (state_d == ST_FLUSH);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_CHECK);
            pass_q    <= pass_d;
        end
    end

    nt_probe_misr u_misr (
        .clk_i      (I1470_clk),
        .rst_ni     (I1477_rst),
        .clr_i      (accept),
        .en_i       (pipe_q[LAT-1]),
        .din_i      (dut_q),
        .sig_o      (misr_sig),
        .sig_next_o (misr_next)
    );

    assign dut_d     = dut_d_q;
    assign dut_rst   = dut_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_sig;
    assign pat_cnt   = pat_cnt_q;

endmodule

// File: tb/tb_nt_probe_sequencer.sv
// Scoreboard bench: five sequencer configurations with hand-computed signatures.
module tb_nt_probe_sequencer;

    localparam int N = 5;

    function automatic int p_of(input int i);
        case (i)
            0: return 5;
            1: return 4;
            2: return 2;
            3: return 1;
            default: return 20;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        case (i)
            3: return 4;
            4: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] seed_of(input int i);
        return (i == 4) ? 8'h00 : 8'h01;
    endfunction

    function automatic logic [15:0] gold_of(input int i);
        case (i)
            0: return 16'h001F;
            4: return 16'h0E10;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic q_of(input int i);
        return (i != 1);
    endfunction

    // Hand-computed final signatures for an all-ones / all-zeros response stream.
    function automatic logic [15:0] exp_sig_of(input int i);
        case (i)
            0: return 16'h001F;
            1: return 16'h0000;
            2: return 16'h0003;
            3: return 16'h0001;
            default: return 16'h0E10;
        endcase
    endfunction

    function automatic logic exp_pass_of(input int i);
        return (i == 0) || (i == 1) || (i == 4);
    endfunction

    typedef struct {
        int          id;
        logic [15:0] sig;
        logic        pass;
        int          stamp;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;

    logic        rst_n   [N];
    logic        start_r [N];
    logic [2:0]  dut_d_w [N];
    logic        dut_rst_w [N];
    logic        busy_w  [N];
    logic        done_w  [N];
    logic        pass_w  [N];
    logic [15:0] sig_w   [N];
    logic [10:0] pat_w   [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            localparam logic QV = q_of(gi);
            nt_probe_sequencer #(
                .PATTERNS  (p_of(gi)),
                .LAT       (lat_of(gi)),
                .LFSR_SEED (seed_of(gi)),
                .GOLDEN    (gold_of(gi))
            ) u_dut (
                .I1470_clk (clk),
                .I1477_rst (rst_n[gi]),
                .start     (start_r[gi]),
                .dut_d     (dut_d_w[gi]),
                .dut_rst   (dut_rst_w[gi]),
                .dut_q     (QV),
                .busy      (busy_w[gi]),
                .done      (done_w[gi]),
                .pass      (pass_w[gi]),
                .signature (sig_w[gi]),
                .pat_cnt   (pat_w[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst %0d: got %0h required %0h", name, inst, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (done_w[i] === 1'b1) begin
                if (sb_q.size() == 0 || sb_q[0].id != i) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_done inst %0d cycle %0d: got done=1 required no done", i, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("signature", i, 32'(sig_w[i]), 32'(mon_e.sig));
                    chk("pass", i, 32'(pass_w[i]), 32'(mon_e.pass));
                    chk("done_cycle", i, cyc, mon_e.stamp);
                    $display("done inst %0d cycle %0d sig %04h pass %0b", i, cyc, sig_w[i], pass_w[i]);
                end
            end
        end
    end

    task automatic do_start(input int i, output int k);
        start_r[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[i] = 1'b0;
        k = cyc;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (sb_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: got %0d pending results required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic push_exp(input int i, input int k);
        exp_t e;
        e.id    = i;
        e.sig   = exp_sig_of(i);
        e.pass  = exp_pass_of(i);
        e.stamp = k + p_of(i) + lat_of(i) + 2;
        sb_q.push_back(e);
    endtask

    task automatic run_basic(input int i);
        int k;
        do_start(i, k);
        push_exp(i, k);
        chk("flush_rst", i, 32'(dut_rst_w[i]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("first_pattern", i, 32'(dut_d_w[i]), 32'd1);
        wait_drain(2000);
        @(negedge clk);
        chk("pat_cnt_end", i, 32'(pat_w[i]), 32'(p_of(i)));
        chk("sig_held", i, 32'(sig_w[i]), 32'(exp_sig_of(i)));
        chk("pass_held", i, 32'(pass_w[i]), 32'(exp_pass_of(i)));
        chk("idle_busy", i, 32'(busy_w[i]), 32'd0);
    endtask

    initial begin
        int          k;
        int          t;
        logic [2:0]  exp_d;
        logic [2:0]  seq_a [5];
        seq_a = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001};

        for (int i = 0; i < N; i++) begin
            rst_n[i]   = 1'b0;
            start_r[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
            chk("rst_done", i, 32'(done_w[i]), 32'd0);
            chk("rst_pass", i, 32'(pass_w[i]), 32'd0);
            chk("rst_sig", i, 32'(sig_w[i]), 32'd0);
            chk("rst_pat_cnt", i, 32'(pat_w[i]), 32'd0);
            chk("rst_dut_rst", i, 32'(dut_rst_w[i]), 32'd1);
            chk("rst_dut_d", i, 32'(dut_d_w[i]), 32'd0);
        end
        // start coincident with reset must be ignored
        start_r[1] = 1'b1;
        @(negedge clk);
        start_r[1] = 1'b0;
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        chk("start_in_reset_busy", 1, 32'(busy_w[1]), 32'd0);
        for (int i = 0; i < N; i++) chk("idle_dut_rst", i, 32'(dut_rst_w[i]), 32'd0);

        // Abort mid-DRIVE: no done may follow (monitor flags any stray pulse).
        do_start(0, k);
        t = 0;
        while (pat_w[0] != 11'd3 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reach_pat3", 0, 32'(pat_w[0]), 32'd3);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        chk("abort_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("abort_dut_rst", 0, 32'(dut_rst_w[0]), 32'd1);
        chk("abort_sig", 0, 32'(sig_w[0]), 32'd0);
        chk("abort_pat_cnt", 0, 32'(pat_w[0]), 32'd0);
        chk("abort_dut_d", 0, 32'(dut_d_w[0]), 32'd0);
        $display("abort inst 0 cycle %0d busy %0b sig %04h", cyc, busy_w[0], sig_w[0]);
        repeat (15) @(negedge clk);

        // Full run on instance 0 with ignored starts in DRIVE and in the done cycle.
        do_start(0, k);
        push_exp(0, k);
        for (int n = 1; n <= 9; n++) begin
            exp_d = (n >= 3 && n <= 7) ? seq_a[n-3] : 3'b000;
            chk("dut_d", 0, 32'(dut_d_w[0]), 32'(exp_d));
            chk("dut_rst", 0, 32'(dut_rst_w[0]), 32'(n <= 2));
            chk("busy", 0, 32'(busy_w[0]), 32'd1);
            $display("cycle k+%0d inst 0 dut_d %03b dut_rst %0b", n, dut_d_w[0], dut_rst_w[0]);
            start_r[0] = (n == 4 || n == 9);
            @(negedge clk);
        end
        start_r[0] = 1'b1;
        chk("post_done_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("post_done_pat_cnt", 0, 32'(pat_w[0]), 32'd5);
        chk("post_done_sig", 0, 32'(sig_w[0]), 32'h001F);
        chk("post_done_pass", 0, 32'(pass_w[0]), 32'd1);
        @(negedge clk);
        start_r[0] = 1'b0;
        chk("restart_busy", 0, 32'(busy_w[0]), 32'd1);
        chk("restart_dut_rst", 0, 32'(dut_rst_w[0]), 32'd1);
        chk("restart_pat_cnt", 0, 32'(pat_w[0]), 32'd0);
        chk("restart_pass_clr", 0, 32'(pass_w[0]), 32'd0);
        push_exp(0, cyc);
        wait_drain(40);
        @(negedge clk);

        for (int i = 1; i < N; i++) run_basic(i);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
